// File: rtl/timer_apb_master.sv
// Single-outstanding APB requester for the timer register block.
// Turns one host command into one APB transfer and returns a registered response pulse.
// Adds a bounded wait on pready and rejects misaligned addresses without touching the bus.
module timer_apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  // Host command channel
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  // Host response channel
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // APB requester towards timer_top
  output logic        tim_psel,
  output logic        tim_penable,
  output logic        tim_pwrite,
  output logic [11:0] tim_paddr,
  output logic [31:0] tim_pwdata,
  output logic [3:0]  tim_pstrb,
  input  logic [31:0] tim_prdata,
  input  logic        tim_pready,
  input  logic        tim_pslverr
);

  // Keep at least one counter bit so a disabled timeout still elaborates.
  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  state_e          state;
  logic [CntW-1:0] wait_cnt;
  logic [CntW-1:0] wait_cnt_inc;
  logic            timeout_hit;

  // Commands are only taken in IDLE and never while reset is held.
  assign cmd_ready = sys_rst_n && (state == StIdle);

  // Count of ACCESS edges without pready, including the edge being evaluated now.
  assign wait_cnt_inc = wait_cnt + CntW'(1);
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (wait_cnt_inc == CntLimit);

  // Transfer FSM with all bus and response outputs registered.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= StIdle;
      wait_cnt    <= '0;
      tim_psel    <= 1'b0;
      tim_penable <= 1'b0;
      tim_pwrite  <= 1'b0;
      tim_paddr   <= '0;
      tim_pwdata  <= '0;
      tim_pstrb   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_addr[1:0] != 2'b00) begin
              // Misaligned: answer with an error straight away, bus stays quiet.
              state       <= StResp;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
            end else begin
              state       <= StSetup;
              tim_psel    <= 1'b1;
              tim_penable <= 1'b0;
              tim_pwrite  <= cmd_write;
              tim_paddr   <= cmd_addr;
              tim_pwdata  <= cmd_write ? cmd_wdata : 32'h0;
              tim_pstrb   <= cmd_write ? cmd_strb : 4'h0;
            end
          end
        end

        StSetup: begin
          state       <= StAccess;
          tim_penable <= 1'b1;
          wait_cnt    <= '0;
        end

        StAccess: begin
          if (tim_pready) begin
            // Completion beats a timeout landing on the same edge.
            state       <= StResp;
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= tim_pslverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!tim_pwrite && !tim_pslverr) ? tim_prdata : 32'h0;
          end else if (timeout_hit) begin
            state       <= StResp;
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else if (wait_cnt != CntMax) begin
            wait_cnt <= wait_cnt_inc;
          end
        end

        StResp: begin
          state       <= StIdle;
          rsp_valid   <= 1'b0;
          rsp_err     <= 1'b0;
          rsp_timeout <= 1'b0;
          rsp_rdata   <= '0;
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/timer_apb_master.md
TIMER_APB_MASTER -- requirements
Module: timer_apb_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, number of consecutive ACCESS-phase edges without tim_pready before abort; 0 disables timeout.
REQ-002 sys_clk  in  1  single clock; all state updates on rising edge.
REQ-003 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  host requests one register transfer.
REQ-005 cmd_ready  out  1  block can accept a command; cmd_valid & cmd_ready at a rising edge = accepted.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  12  byte address of timer register.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 cmd_strb  in  4  byte-lane write strobes.
REQ-010 rsp_valid  out  1  one-cycle pulse; response fields valid.
REQ-011 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-012 rsp_err  out  1  transfer failed (pslverr, timeout, or misaligned).
REQ-013 rsp_timeout  out  1  failure cause was timeout.
REQ-014 tim_psel, tim_penable, tim_pwrite  out  1 each  APB control to timer_top.
REQ-015 tim_paddr  out  12; tim_pwdata  out  32; tim_pstrb  out  4  APB address/data/strobe to timer_top.
REQ-016 tim_prdata  in  32; tim_pready  in  1; tim_pslverr  in  1  APB completion from timer_top.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS, RESP; all APB outputs and rsp_* are registered.
REQ-018 cmd_ready = 1 only in IDLE; commands are never buffered, one outstanding transfer max.
REQ-019 Accept edge E0 in IDLE with cmd_addr[1:0] = 0: latch addr/wdata/write/strb, go SETUP; psel=1, penable=0 from E0.
REQ-020 tim_pstrb = latched cmd_strb for writes, 4'h0 for reads; tim_pwdata = 0 for reads.
REQ-021 Edge E1: SETUP -> ACCESS unconditionally; penable=1; addr, pwrite, pwdata, pstrb held stable from E0 until psel drops.
REQ-022 In ACCESS, any edge sampling tim_pready=1: capture tim_prdata (reads only) and tim_pslverr, drop psel and penable, go RESP.
REQ-023 Minimum latency: zero-wait slave completes at E2, rsp_valid high during cycle after E2, IDLE after E3, next accept no earlier than E4.
REQ-024 RESP lasts exactly one cycle: rsp_valid=1, rsp_err=pslverr, rsp_timeout=0; rsp_rdata = captured data unless err, then 0.
REQ-025 Wait counter: cleared on entering ACCESS, +1 per ACCESS edge with pready=0; at TIMEOUT_CYCLES such edges: drop psel/penable, go RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-026 Counter width ceil(log2(TIMEOUT_CYCLES+1)), saturates, never wraps; TIMEOUT_CYCLES=0 waits forever.
REQ-027 pready=1 on the same edge the counter reaches the limit: completion wins, no timeout.
REQ-028 Misaligned accept (cmd_addr[1:0] != 0): no APB activity, go RESP directly, rsp_err=1, rsp_timeout=0.
REQ-029 rsp_* outputs are 0 whenever rsp_valid=0.
REQ-030 tim_pslverr, tim_prdata ignored outside the completing ACCESS edge.

Reset
REQ-031 sys_rst_n low: immediately state=IDLE, counter=0, all APB outputs 0, rsp_* 0, cmd_ready=0 while reset asserted, 1 from first cycle after release.
REQ-032 Reset mid-transfer (SETUP/ACCESS) aborts with no response pulse; psel/penable drop asynchronously.

Verification
REQ-033 Write 0x000 data 0x0000_0001 strb 0xF, zero-wait slave -> psel 2 cycles, penable 1 cycle, pstrb 0xF, rsp_valid 1 cycle after E2, err=0.
REQ-034 After reset read 0x00C -> pstrb 0x0, rsp_rdata 0xFFFF_FFFF, err=0; read 0x000 -> 0x0000_0100.
REQ-035 Write to unmapped 0xFFC with slave asserting pslverr -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-036 TIMEOUT_CYCLES=4, pready held 0 -> psel drops after 4 ACCESS edges, rsp_err=1, rsp_timeout=1; pready on 4th edge -> normal completion.
REQ-037 Command addr 0x00D -> no psel, rsp_valid next cycle with rsp_err=1.
REQ-038 Assert sys_rst_n low during ACCESS -> psel/penable 0 without clock edge, no rsp_valid, next command proceeds normally.
